// File: rtl/sc64_pkg.sv
// PI bus definitions shared by the cartridge-side target (n64_pi) and the
// console-side initiator (n64_pi_host).
package sc64;

  // {aleh, alel} bus mode as seen on the cartridge edge
  typedef enum logic [1:0] {
    PI_MODE_VALID = 2'b00,
    PI_MODE_LOW   = 2'b01,
    PI_MODE_IDLE  = 2'b10,
    PI_MODE_HIGH  = 2'b11
  } e_pi_mode;

  // The PI address latch auto-increments only within a 512-byte block
  localparam int PI_BLOCK_BITS = 9;

endpackage

// File: rtl/n64_pi_host.sv
// Console-side PI bus initiator: issues ALEH/ALEL address phases and
// READ/WRITE strobes for bursts of 1..256 halfwords.
module n64_pi_host
  import sc64::*;
#(
  parameter int ALE_CYCLES   = 8,
  parameter int SETUP_CYCLES = 16,
  parameter int PULSE_CYCLES = 12,
  parameter int GAP_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [7:0]  length,
  output logic        busy,
  input  logic [15:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        pi_aleh,
  output logic        pi_alel,
  output logic        pi_read,
  output logic        pi_write,
  output logic [15:0] pi_ad_out,
  output logic        pi_ad_oe,
  input  logic [15:0] pi_ad_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_HIGH, S_LOW, S_SETUP, S_PULSE, S_GAP, S_IDLE_BRIEF, S_DONE
  } e_state;

  localparam logic [7:0] ALE_LOAD   = 8'(ALE_CYCLES - 1);
  localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

  e_state      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [8:0]  words_q, words_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [15:0] ad_out_q, ad_out_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;

  logic        cnt_done;
  logic [31:0] addr_next;
  logic        pulse_ok;
  e_pi_mode    mode;
  logic        oe;

  assign cnt_done  = (cnt_q == 8'd0);
  assign addr_next = addr_q + 32'd2;
  // Writes may only enter a pulse once a data word is on offer
  assign pulse_ok  = !write_q || wdata_valid;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_done ? cnt_q : cnt_q - 8'd1;
    words_d       = words_q;
    addr_d        = addr_q;
    write_d       = write_q;
    ad_out_d      = ad_out_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    wdata_ready   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_HIGH;
        cnt_d    = ALE_LOAD;
        words_d  = {1'b0, length};
        addr_d   = address & 32'hFFFF_FFFE;
        write_d  = write;
        ad_out_d = address[31:16];
      end
      S_HIGH: if (cnt_done) begin
        state_d  = S_LOW;
        cnt_d    = ALE_LOAD;
        ad_out_d = addr_q[15:0];
      end
      S_LOW: if (cnt_done) begin
        state_d = S_SETUP;
        cnt_d   = SETUP_LOAD;
      end
      S_SETUP: if (cnt_done && pulse_ok) begin
        state_d     = S_PULSE;
        cnt_d       = PULSE_LOAD;
        wdata_ready = write_q;
        if (write_q) ad_out_d = wdata;
      end
      S_PULSE: if (cnt_done) begin
        state_d = S_GAP;
        cnt_d   = GAP_LOAD;
        if (!write_q) begin
          rdata_d       = pi_ad_in;
          rdata_valid_d = 1'b1;
        end
      end
      S_GAP: if (cnt_done) begin
        if (words_q == 9'd0) begin
          state_d = S_DONE;
        end else if (addr_next[PI_BLOCK_BITS-1:0] == '0) begin
          // Crossing a 512-byte block (including the 32-bit wrap) needs a fresh address phase
          state_d = S_IDLE_BRIEF;
          addr_d  = addr_next;
          words_d = words_q - 9'd1;
        end else if (pulse_ok) begin
          state_d     = S_PULSE;
          cnt_d       = PULSE_LOAD;
          addr_d      = addr_next;
          words_d     = words_q - 9'd1;
          wdata_ready = write_q;
          if (write_q) ad_out_d = wdata;
        end
      end
      S_IDLE_BRIEF: begin
        state_d  = S_HIGH;
        cnt_d    = ALE_LOAD;
        ad_out_d = addr_q[31:16];
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      words_q       <= 9'd0;
      addr_q        <= 32'd0;
      write_q       <= 1'b0;
      ad_out_q      <= 16'd0;
      rdata_q       <= 16'd0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      words_q       <= words_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      ad_out_q      <= ad_out_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  always_comb begin
    mode = PI_MODE_IDLE;
    oe   = 1'b0;
    case (state_q)
      S_HIGH: begin mode = PI_MODE_HIGH; oe = 1'b1; end
      S_LOW:  begin mode = PI_MODE_LOW;  oe = 1'b1; end
      S_SETUP, S_PULSE, S_GAP: begin mode = PI_MODE_VALID; oe = write_q; end
      default: ;
    endcase
  end

  assign pi_aleh     = mode[1];
  assign pi_alel     = mode[0];
  assign pi_ad_oe    = oe;
  assign pi_ad_out   = ad_out_q;
  assign pi_read     = !(state_q == S_PULSE && !write_q);
  // First pulse cycle keeps WRITE high so data leads the falling edge
  assign pi_write    = !(state_q == S_PULSE && write_q && cnt_q != PULSE_LOAD);
  assign busy        = (state_q != S_IDLE);
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_n64_pi_host.sv
// Randomized scoreboard bench for n64_pi_host; the bench plays the cartridge
// target and predicts every latch, strobe and data word from the command.
module tb_n64_pi_host;
  import sc64::*;

  localparam int ALE = 8, SETUP = 16, PULSE = 12, GAP = 4;

  logic        clk = 1'b0;
  logic        reset, start, write, wdata_valid;
  logic [31:0] address;
  logic [7:0]  length;
  logic [15:0] wdata;
  logic        busy, wdata_ready, rdata_valid;
  logic        pi_aleh, pi_alel, pi_read, pi_write, pi_ad_oe;
  logic [15:0] rdata, pi_ad_out, pi_ad_in;

  int tests = 0, fails = 0;
  int strobes = 0, readies = 0;
  logic [31:0] tgt_addr = 32'd0;
  logic [31:0] exp_latch[$];
  logic [15:0] exp_rd[$];
  logic [47:0] exp_wr[$];
  logic [15:0] wq[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    return a[16:1] ^ a[31:16] ^ 16'hA55A;
  endfunction

  assign pi_ad_in = mem_word(tgt_addr);

  n64_pi_host #(.ALE_CYCLES(ALE), .SETUP_CYCLES(SETUP), .PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .write(write), .address(address),
    .length(length), .busy(busy), .wdata(wdata), .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready), .rdata(rdata), .rdata_valid(rdata_valid),
    .pi_aleh(pi_aleh), .pi_alel(pi_alel), .pi_read(pi_read), .pi_write(pi_write),
    .pi_ad_out(pi_ad_out), .pi_ad_oe(pi_ad_oe), .pi_ad_in(pi_ad_in)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  // Target-side monitor and scoreboard
  initial begin
    logic [1:0] m, pmode;
    logic pread, pwrite;
    logic [15:0] pad, hi, lo;
    int hrun, lrun, since, rlow, wlow;
    bit after_latch, timing_ok;
    pmode = 2'b10; pread = 1'b1; pwrite = 1'b1; pad = 16'h0; hi = 16'h0; lo = 16'h0;
    hrun = 0; lrun = 0; since = 0; rlow = 0; wlow = 0; after_latch = 0; timing_ok = 0;
    forever begin
      @(negedge clk);
      m = {pi_aleh, pi_alel};
      if (reset) begin
        hrun = 0; lrun = 0; since = 0; rlow = 0; wlow = 0; timing_ok = 0;
        pmode = 2'b10; pread = 1'b1; pwrite = 1'b1; pad = pi_ad_out;
      end else begin
        if (m != 2'b00) timing_ok = 0;
        if (m == 2'b11) begin hi = pi_ad_out; hrun++; end
        else if (pmode == 2'b11) begin chk("aleh_len", hrun, ALE); hrun = 0; end
        if (m == 2'b01) begin lo = pi_ad_out; lrun++; end
        else if (pmode == 2'b01) begin
          chk("alel_len", lrun, ALE); lrun = 0;
          if (m == 2'b00) begin
            if (exp_latch.size() == 0) bad("unexpected_latch");
            else chk("latch_addr", longint'({hi, lo}), longint'(exp_latch.pop_front()));
            tgt_addr = {hi, lo}; since = 0; after_latch = 1; timing_ok = 1;
          end
        end
        // read strobe timing and target address advance
        if (!pi_read && pread) begin
          if (timing_ok) chk(after_latch ? "read_setup" : "read_gap", since, after_latch ? SETUP : GAP);
          rlow = 0;
        end
        if (!pi_read) rlow++;
        if (pi_read && !pread) begin
          chk("read_low", rlow, PULSE);
          strobes++; tgt_addr += 32'd2; since = 0; after_latch = 0; timing_ok = 1;
        end
        if (m == 2'b00 && pi_read && pi_write) since++;
        // write strobe: data must already be on AD the cycle before the fall
        if (!pi_write && pwrite) begin
          chk("wr_data_lead", longint'(pi_ad_out), longint'(pad));
          wlow = 0;
        end
        if (!pi_write) wlow++;
        if (pi_write && !pwrite) begin
          chk("write_low", wlow, PULSE - 1);
          strobes++;
          if (exp_wr.size() == 0) bad("unexpected_write");
          else chk("write_word", longint'({tgt_addr, pi_ad_out}), longint'(exp_wr.pop_front()));
          tgt_addr += 32'd2;
        end
        if (rdata_valid) begin
          if (exp_rd.size() == 0) bad("unexpected_rdata");
          else chk("rdata", longint'(rdata), longint'(exp_rd.pop_front()));
        end
        if (wdata_ready) readies++;
        if (!pi_read && !pi_write) bad("read_and_write_low");
        if (pi_ad_oe && !pi_read) bad("oe_during_read");
        pmode = m; pread = pi_read; pwrite = pi_write; pad = pi_ad_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Reference: word i lives at start+2i (32-bit wrap); a new address phase
  // precedes word 0 and every word that starts a 512-byte block.
  task automatic plan(input bit wr, input logic [31:0] a, input int len,
                      input logic [15:0] d0, input logic [15:0] d1);
    logic [31:0] aa;
    logic [15:0] d;
    aa = a & 32'hFFFF_FFFE;
    wq.delete();
    for (int i = 0; i <= len; i++) begin
      if (i == 0 || aa[8:0] == 9'd0) exp_latch.push_back(aa);
      if (wr) begin
        d = (i == 0) ? d0 : (i == 1) ? d1 : 16'($urandom);
        wq.push_back(d);
        exp_wr.push_back({aa, d});
      end else begin
        exp_rd.push_back(mem_word(aa));
      end
      aa = aa + 32'd2;
    end
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input int len);
    start = 1'b1; write = wr; address = a; length = 8'(len);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_cmd(input bit wr, input logic [31:0] a, input int len,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input int stall_word, input bit inject);
    int s0, r0, idx, stall, cyc;
    bit took, done;
    s0 = strobes; r0 = readies; idx = 0; stall = 0; cyc = 0; done = 0;
    plan(wr, a, len, d0, d1);
    issue(wr, a, len);
    while (!done) begin
      wdata_valid = wr && idx <= len && stall == 0;
      wdata = (idx <= len && wr) ? wq[idx] : 16'h0;
      @(negedge clk);
      took = wdata_ready && wdata_valid;
      tick();
      cyc++;
      if (stall > 0) stall--;
      if (took) begin
        idx++;
        if (idx == stall_word) stall = 20;
        else if ($urandom_range(3) == 0) stall = int'($urandom_range(3));
      end
      if (inject && cyc == 30) begin
        start = 1'b1; write = 1'b0; address = 32'hDEAD_0000; length = 8'd5;
      end else start = 1'b0;
      if (!busy) done = 1;
      if (cyc > 10000) begin bad("cmd_timeout"); done = 1; end
    end
    wdata_valid = 1'b0;
    repeat (2) tick();
    chk("strobe_count", strobes - s0, len + 1);
    if (wr) chk("wdata_ready_count", readies - r0, len + 1);
    chk("latch_left", exp_latch.size(), 0);
    chk("rdata_left", exp_rd.size(), 0);
    chk("write_left", exp_wr.size(), 0);
    exp_latch.delete(); exp_rd.delete(); exp_wr.delete();
  endtask

  task automatic reset_mid_burst();
    int falls, lowc, cyc;
    logic pr;
    falls = 0; lowc = 0; cyc = 0; pr = 1'b1;
    plan(0, 32'h1000_0100, 7, 16'h0, 16'h0);
    issue(0, 32'h1000_0100, 7);
    while (cyc < 2000) begin
      tick();
      cyc++;
      if (!pi_read && pr) falls++;
      if (!pi_read) lowc++; else lowc = 0;
      pr = pi_read;
      if (falls == 5 && lowc == 3) break;
    end
    if (cyc >= 2000) bad("reset_test_timeout");
    chk("words_before_reset", exp_rd.size(), 4);
    reset = 1'b1;
    tick();
    chk("rst_mid_aleh", pi_aleh, 1);
    chk("rst_mid_alel", pi_alel, 0);
    chk("rst_mid_read", pi_read, 1);
    chk("rst_mid_oe", pi_ad_oe, 0);
    chk("rst_mid_busy", busy, 0);
    reset = 1'b0;
    exp_latch.delete(); exp_rd.delete(); exp_wr.delete();
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int sel;
    reset = 1'b1; start = 1'b0; write = 1'b0; address = 32'h0; length = 8'h0;
    wdata = 16'h0; wdata_valid = 1'b0;
    repeat (3) tick();
    chk("rst_aleh", pi_aleh, 1);
    chk("rst_alel", pi_alel, 0);
    chk("rst_strobes", longint'({pi_read, pi_write}), 3);
    chk("rst_oe", pi_ad_oe, 0);
    chk("rst_ad_out", pi_ad_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_handshakes", longint'({wdata_ready, rdata_valid}), 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b0;
    tick();

    run_cmd(0, 32'h1000_0000, 3, 16'h0, 16'h0, -1, 0);
    run_cmd(1, 32'h0800_0010, 1, 16'hBEEF, 16'hCAFE, -1, 0);
    run_cmd(0, 32'h1000_01FC, 3, 16'h0, 16'h0, -1, 0);
    run_cmd(1, 32'h0800_0100, 3, 16'h1234, 16'h5678, 1, 0);
    run_cmd(0, 32'h1000_0000, 4, 16'h0, 16'h0, -1, 1);
    run_cmd(0, 32'hFFFF_FFFC, 3, 16'h0, 16'h0, -1, 0);
    run_cmd(1, 32'hFFFF_FFFA, 2, 16'h0F0F, 16'hF0F0, -1, 0);
    reset_mid_burst();
    run_cmd(0, 32'h1000_0100, 255, 16'h0, 16'h0, -1, 0);

    for (int n = 0; n < 20; n++) begin
      sel = int'($urandom_range(3));
      case (sel)
        1: a = ($urandom & 32'hFFFF_FE00) | (32'h200 - 32'(2 * $urandom_range(1, 4)));
        2: a = 32'hFFFF_FFF0 | ($urandom & 32'hE);
        default: a = $urandom;
      endcase
      run_cmd(1'($urandom_range(1)), a, int'($urandom_range(9)),
              16'($urandom), 16'($urandom), -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
